// File: rtl/l1_rd_ret.sv
// l1_rd_ret: L1 read-port data return stage.
// Accepts one {sid, ptr} read per cycle and reads the L1 BRAM, which has a fixed latency.
// The returned word and its stream id go into a small in-order FIFO,
// which is drained by the AFU over a valid/ready handshake.
// Before a read is issued, a credit counter reserves a FIFO slot for it,
// so BRAM data is never dropped under AFU backpressure.
module l1_rd_ret #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int ptr_width    = 1,
  parameter int data_width   = 64,
  parameter int rd_lat       = 2,
  parameter int fifo_depth   = 4,
  parameter int cnt_width    = $clog2(fifo_depth + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_addr_v,
  output logic                          i_addr_r,
  input  logic [ptr_width-1:0]          i_addr_ptr,
  input  logic [nstrms_width-1:0]       i_addr_sid,
  output logic                          o_bram_re,
  output logic [nstrms_width+ptr_width-1:0] o_bram_addr,
  input  logic [data_width-1:0]         i_bram_data,
  output logic                          o_rd_v,
  input  logic                          o_rd_r,
  output logic [data_width-1:0]         o_rd_data,
  output logic [nstrms_width-1:0]       o_rd_sid,
  output logic                          o_idle
);

  localparam int idx_width = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  // used counts reads in flight plus entries in the FIFO.
  logic [cnt_width-1:0]    used;
  logic [cnt_width-1:0]    fifo_cnt;
  logic                    accept;
  logic                    push;
  logic                    pop;

  logic [rd_lat-1:0]       pipe_v;
  logic [nstrms_width-1:0] pipe_sid [rd_lat];

  logic [data_width-1:0]   fifo_data [fifo_depth];
  logic [nstrms_width-1:0] fifo_sid  [fifo_depth];
  logic [idx_width-1:0]    wr_idx;
  logic [idx_width-1:0]    rd_idx;

  function automatic logic [idx_width-1:0] next_idx(input logic [idx_width-1:0] idx);
    if (idx == idx_width'(fifo_depth - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Readiness depends only on the registered count.
  // A pop in the same cycle does not free a slot until the next cycle.
  assign i_addr_r    = reset & (used < cnt_width'(fifo_depth));
  assign accept      = i_addr_v & i_addr_r;
  assign o_bram_re   = accept;
  assign o_bram_addr = {i_addr_sid, i_addr_ptr};

  assign push      = pipe_v[rd_lat-1];
  assign o_rd_v    = (fifo_cnt != '0);
  assign pop       = o_rd_v & o_rd_r;
  assign o_rd_data = fifo_data[rd_idx];
  assign o_rd_sid  = fifo_sid[rd_idx];
  assign o_idle    = (used == '0);

  // Credit counter: +1 on each accepted read, -1 on each pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used <= '0;
    end else if (accept && !pop) begin
      used <= used + 1'b1;
    end else if (!accept && pop) begin
      used <= used - 1'b1;
    end
  end

  // Valid bits of the issue pipeline, which tracks the BRAM latency and never stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < rd_lat; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Stream ids travel alongside the valids; the valids alone qualify them.
  always_ff @(posedge clk) begin
    pipe_sid[0] <= i_addr_sid;
    for (int i = 1; i < rd_lat; i++) pipe_sid[i] <= pipe_sid[i-1];
  end

  // FIFO pointers and occupancy; push and pop may occur together even when the FIFO is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= next_idx(wr_idx);
      if (pop)  rd_idx <= next_idx(rd_idx);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // FIFO storage, written by the last pipeline stage. Entries are qualified by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_idx] <= i_bram_data;
      fifo_sid[wr_idx]  <= pipe_sid[rd_lat-1];
    end
  end

  // The credit rule guarantees these properties; a violation indicates a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && fifo_cnt == cnt_width'(fifo_depth)));
  a_used_bound: assert property (@(posedge clk) disable iff (!reset)
    used <= cnt_width'(fifo_depth));

endmodule
